fp_add_sub_unit: RTL and testbench



---
 rtl/fp_add_sub_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_fp_add_sub_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fp_add_sub_unit.sv
// Multi-cycle parametrised floating-point adder/subtractor with start/done handshake.
// Define FP_SPECIAL_CASES_EN to decode Inf/NaN operands and return Inf on overflow.
module fp_add_sub_unit #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 op_sub,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 flag_ovf,
  output logic                 flag_unf,
  output logic                 flag_zero
);

  localparam int unsigned W  = EXP_W + MAN_W + 1;
  localparam int unsigned XW = MAN_W + 4;  // hidden, frac, G, R, S
  localparam int unsigned SW = MAN_W + 5;  // carry + XW
  localparam logic [EXP_W:0] EXP_ONES = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EXP_ONE  = (EXP_W + 1)'(1);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  state_t state, state_n;

  logic [W-1:0]    a_r, b_r;
  logic            op_r;
  logic [EXP_W:0]  exp_r;
  logic            sign_r, eff_sub_r;
  logic [XW-1:0]   big_r, small_r;
  logic [SW-1:0]   sum_r;
  logic [W-1:0]    res_p;
  logic            ovf_p, unf_p, zero_p;

  // Alignment datapath, evaluated from the captured operands
  logic                   sa, sb, za, zb, a_big;
  logic [EXP_W-1:0]       ea, eb, e_big, e_small;
  logic [EXP_W+MAN_W-1:0] mag_a, mag_b;
  logic [XW-1:0]          x_a, x_b, x_big, x_small, x_shift;
  logic [31:0]            diff;

  always_comb begin
    sa      = a_r[W-1];
    sb      = b_r[W-1] ^ op_r;
    ea      = a_r[W-2:MAN_W];
    eb      = b_r[W-2:MAN_W];
    za      = (ea == '0);
    zb      = (eb == '0);
    mag_a   = za ? '0 : a_r[W-2:0];
    mag_b   = zb ? '0 : b_r[W-2:0];
    x_a     = za ? '0 : {1'b1, a_r[MAN_W-1:0], 3'b000};
    x_b     = zb ? '0 : {1'b1, b_r[MAN_W-1:0], 3'b000};
    a_big   = (mag_a >= mag_b);
    e_big   = a_big ? ea : eb;
    e_small = a_big ? eb : ea;
    x_big   = a_big ? x_a : x_b;
    x_small = a_big ? x_b : x_a;
    diff    = 32'(e_big) - 32'(e_small);
    if (diff >= 32'(XW - 1))
      x_shift = {{(XW-1){1'b0}}, |x_small};
    else
      x_shift = (x_small >> diff)
              | {{(XW-1){1'b0}}, |(x_small & ~({XW{1'b1}} << diff))};
  end

  logic         special;
  logic [W-1:0] spec_res;
  logic [W-1:0] ovf_res;

`ifdef FP_SPECIAL_CASES_EN
  logic a_ones, b_ones, is_nan;
  always_comb begin
    a_ones  = &ea;
    b_ones  = &eb;
    special = a_ones | b_ones;
    is_nan  = (a_ones & |a_r[MAN_W-1:0]) | (b_ones & |b_r[MAN_W-1:0])
            | (a_ones & b_ones & (sa ^ sb));
    if (is_nan)
      spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    else if (a_ones)
      spec_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      spec_res = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end
  assign ovf_res = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
  assign special  = 1'b0;
  assign spec_res = '0;
  assign ovf_res  = {sign_r, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif

  // Magnitude add/subtract; big_r >= small_r so the difference never goes negative
  logic [SW-1:0] sum_c;
  always_comb begin
    if (eff_sub_r)
      sum_c = {1'b0, big_r} - {1'b0, small_r};
    else
      sum_c = {1'b0, big_r} + {1'b0, small_r};
  end

  // Round to nearest even on G/R/S
  logic [MAN_W:0]   mant;
  logic             rnd_inc;
  logic [MAN_W+1:0] m_rnd;
  logic [EXP_W:0]   e_rnd;
  logic [MAN_W-1:0] frac_rnd;
  logic             ovf_c;
  logic [W-1:0]     norm_res;

  always_comb begin
    mant     = sum_r[SW-2:3];
    rnd_inc  = sum_r[2] & (sum_r[1] | sum_r[0] | mant[0]);
    m_rnd    = {1'b0, mant} + (MAN_W + 2)'(rnd_inc);
    e_rnd    = exp_r + (EXP_W + 1)'(m_rnd[MAN_W+1]);
    frac_rnd = m_rnd[MAN_W+1] ? m_rnd[MAN_W:1] : m_rnd[MAN_W-1:0];
    ovf_c    = (e_rnd >= EXP_ONES);
    norm_res = {sign_r, e_rnd[EXP_W-1:0], frac_rnd};
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = ALIGN;
      ALIGN: state_n = special ? DONE : ADD;
      ADD:   state_n = (sum_c == '0) ? DONE : NORM;
      NORM: begin
        if (sum_r[SW-1] || sum_r[SW-2]) state_n = ROUND;
        else if (exp_r == EXP_ONE)      state_n = DONE;
      end
      ROUND: state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= (state == DONE);
      // busy covers the done cycle; a start taken in that cycle keeps it high
      busy  <= ((state == IDLE) && start) || (busy && !done);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= 1'b0;
      exp_r     <= '0;
      sign_r    <= 1'b0;
      eff_sub_r <= 1'b0;
      big_r     <= '0;
      small_r   <= '0;
      sum_r     <= '0;
      res_p     <= '0;
      ovf_p     <= 1'b0;
      unf_p     <= 1'b0;
      zero_p    <= 1'b0;
      result    <= '0;
      flag_ovf  <= 1'b0;
      flag_unf  <= 1'b0;
      flag_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r    <= a;
          b_r    <= b;
          op_r   <= op_sub;
          ovf_p  <= 1'b0;
          unf_p  <= 1'b0;
          zero_p <= 1'b0;
        end
        ALIGN: begin
          if (special) res_p <= spec_res;
          exp_r     <= {1'b0, e_big};
          sign_r    <= a_big ? sa : sb;
          eff_sub_r <= sa ^ sb;
          big_r     <= x_big;
          small_r   <= x_shift;
        end
        ADD: begin
          if (sum_c == '0) begin
            res_p  <= '0;
            zero_p <= 1'b1;
          end
          sum_r <= sum_c;
        end
        NORM: begin
          if (sum_r[SW-1]) begin
            sum_r <= {1'b0, sum_r[SW-1:2], sum_r[1] | sum_r[0]};
            exp_r <= exp_r + EXP_ONE;
          end else if (!sum_r[SW-2]) begin
            if (exp_r == EXP_ONE) begin
              res_p  <= {sign_r, {(W-1){1'b0}}};
              unf_p  <= 1'b1;
              zero_p <= 1'b1;
            end else begin
              sum_r <= sum_r << 1;
              exp_r <= exp_r - EXP_ONE;
            end
          end
        end
        ROUND: begin
          res_p <= ovf_c ? ovf_res : norm_res;
          ovf_p <= ovf_c;
        end
        DONE: begin
          result    <= res_p;
          flag_ovf  <= ovf_p;
          flag_unf  <= unf_p;
          flag_zero <= zero_p;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_sub_unit.sv
// Directed table-driven bench for fp_add_sub_unit (single-precision configuration).
module tb_fp_add_sub_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        op_sub = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, flag_ovf, flag_unf, flag_zero;
  logic [31:0] result;

  always #5 clk = ~clk;

  fp_add_sub_unit #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_sub(op_sub),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_zero(flag_zero)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        zero;
    int          lat;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issues one operation; when junk is set, start is re-pulsed during the first busy cycles.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic iop,
                        input bit junk, output int lat);
    @(negedge clk);
    a = ia; b = ib; op_sub = iop; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (lat < 100) begin
      if (junk && lat < 3) begin
        start = 1'b1; a = 32'h3F800000; b = 32'h3F800000; op_sub = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    start = 1'b0;
  endtask

  initial begin
    int lat;
    int ndone;

    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, 5};
    vecs[1]  = '{32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 1'b0, 1'b0, 1'b0, 7};
    vecs[2]  = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 3};
    vecs[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0, 5};
    vecs[4]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0, 1'b0, 5};
`ifdef FP_SPECIAL_CASES_EN
    vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b0, 5};
`else
    vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F7FFFFF, 1'b1, 1'b0, 1'b0, 5};
`endif
    vecs[6]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0, 1'b0, 5};
    vecs[7]  = '{32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 1'b0, 1'b0, 1'b0, 5};
    vecs[8]  = '{32'h00000000, 32'h40490FDB, 1'b0, 32'h40490FDB, 1'b0, 1'b0, 1'b0, 5};
    vecs[9]  = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0, 1'b0, 6};
    vecs[10] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b1, 4};
    vecs[11] = '{32'h80800001, 32'h80800000, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b1, 4};
    vecs[12] = '{32'h3F800000, 32'h2F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0, 5};
    vecs[13] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b0, 1'b0, 1'b0, 5};
    vecs[14] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, 5};
`ifdef FP_SPECIAL_CASES_EN
    vecs[15] = '{32'h7F800000, 32'h00000000, 1'b0, 32'h7F800000, 1'b0, 1'b0, 1'b0, 2};
    vecs[16] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1'b0, 2};
    vecs[17] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0, 1'b0, 2};
`else
    vecs[15] = '{32'h7F800000, 32'h00000000, 1'b0, 32'h7F7FFFFF, 1'b1, 1'b0, 1'b0, 5};
    vecs[16] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7F7FFFFF, 1'b1, 1'b0, 1'b0, 5};
    vecs[17] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1, 3};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {27'd0, busy, done, flag_ovf, flag_unf, flag_zero, result}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, lat);
      check($sformatf("v%0d_done", i), {63'd0, done}, 64'd1);
      check($sformatf("v%0d_result", i), {32'd0, result}, {32'd0, vecs[i].res});
      check($sformatf("v%0d_flags", i), {61'd0, flag_ovf, flag_unf, flag_zero},
            {61'd0, vecs[i].ovf, vecs[i].unf, vecs[i].zero});
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_busy_in_done", i), {63'd0, busy}, 64'd1);
      @(posedge clk); #1;
      check($sformatf("v%0d_after_done", i), {62'd0, busy, done}, 64'd0);
      check($sformatf("v%0d_result_held", i), {32'd0, result}, {32'd0, vecs[i].res});
    end

    // Abort an operation in NORM with reset
    @(negedge clk);
    a = 32'h3FC00000; b = 32'h3FA00000; op_sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_before_reset", {63'd0, busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("abort_reset_outputs", {27'd0, busy, done, flag_ovf, flag_unf, flag_zero, result}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_no_stale_done", 64'(ndone), 64'd0);

    // Fresh operation with start pulses while busy
    run_op(32'h40000000, 32'h40000000, 1'b0, 1'b1, lat);
    check("post_abort_done", {63'd0, done}, 64'd1);
    check("post_abort_result", {32'd0, result}, 64'h40800000);
    check("post_abort_latency", 64'(lat), 64'd5);
    check("post_abort_flags", {61'd0, flag_ovf, flag_unf, flag_zero}, 64'd0);
    ndone = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("busy_start_ignored", 64'(ndone), 64'd0);
    check("post_abort_result_held", {32'd0, result}, 64'h40800000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
